uart_frame_tx: RTL
==================

# uart_frame_tx

Serial UART transmitter for the panel-test controller's PC report link. It takes the 80-bit right-aligned ASCII message, byte count and start strobe produced by the pattern/button controller. It serializes the message as 8N1 frames on `txd`, most-significant used byte first. It is the transmit counterpart of the existing UART receiver that feeds `Rx_data`/`Rx_Donesig`.

## Interface
Parameters:
- `BIT_CNT`, 703: clock cycles per bit (81 MHz / 115200 baud); legal range 2..65535.
- `MAXBYTES`, 10: capacity of `data` in bytes; fixed by the 80-bit port.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  start request; level signal, only its rising edge is used.
- `data`  in  80  message, right-aligned: byte k occupies `data[8k+7:8k]`; byte `nummax-1` is sent first, byte 0 last.
- `nummax`  in  6  number of bytes to send.
- `txd`  out  1  serial line, idle high.
- `busy`  out  1  high while a message is in progress.
- `done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- Reset values: `txd`=1, `busy`=0, `done`=0. Internal state: IDLE, counters 0, `en_d1`=0.
- Start condition is `en`=1 and `en_d1`=0 (registered previous `en`), in IDLE. On that edge the block:
  - latches `data` into an 80-bit shift/hold register;
  - latches the byte count as `min(nummax, 10)`;
  - goes to START and drives `txd`=0, `busy`=1.
- `nummax`=0 at the start condition: request ignored, block stays in IDLE, no `done`.
- State machine:
  - IDLE: `txd`=1.
  - START: `txd`=0 for BIT_CNT cycles.
  - DATA: 8 bits, LSB first, each BIT_CNT cycles.
  - STOP: `txd`=1 for BIT_CNT cycles.
  - After STOP: if bytes remain, go to START of the next byte with no idle gap. Otherwise go to IDLE with `busy`=0 and `done`=1 for exactly one cycle.
- Byte selection: the current byte is `data_l[8*idx+7 -: 8]`, where `idx` counts down from count-1 to 0.
- Counters:
  - bit-period counter: 16-bit, 0..BIT_CNT-1;
  - bit index: 3-bit;
  - byte index: 4-bit.
- Rising edges of `en` while busy are ignored, not queued. `en` held high starts exactly one message; a new edge is needed after `done`.
- `data`/`nummax` changes after the start edge have no effect on the message in flight.
- Async reset mid-message: outputs go to reset values immediately. The message is discarded and the block returns to IDLE.

## Timing
- Latency: `txd` falls and `busy` rises on the first `clk` edge at which `en`=1 is sampled with `en_d1`=0.
- Each bit lasts exactly BIT_CNT cycles; one byte is 10*BIT_CNT cycles.
- A message of N bytes lasts N*10*BIT_CNT cycles from the `txd` fall to the edge that sets `done`=1 and `busy`=0. On that same edge `txd` is already 1.
- Earliest accepted new start: the cycle after `done`, provided `en` shows a fresh rising edge.
- All outputs are registered; there is no combinational path from inputs to `txd`/`busy`/`done`.

## Test plan
All scenarios use BIT_CNT=4.
- `nummax`=3, `data[23:0]`=0x0A300A ("\n0\n"), one `en` edge:
  - `txd` carries bytes 0x0A, 0x30, 0x0A, each as start 0, LSB-first data, stop 1;
  - `busy` is high for 120 cycles, then `done` pulses once;
  - a line-decoding monitor reads exactly 3 bytes.
- `nummax`=10, `data`="\nA08-2_V4\n": decoded sequence is 0x0A, 0x41, 0x30, 0x38, 0x2D, 0x32, 0x5F, 0x56, 0x34, 0x0A; `done` at cycle 400 after start.
- `en` held high for 1000 cycles with `nummax`=3: exactly one message. A second `en` edge at cycle 60 (mid-message) is ignored. An edge issued after `done` starts a second identical message.
- `nummax`=0: `txd` stays 1 and `busy`/`done` stay 0. `nummax`=15: exactly 10 bytes sent, starting from `data[79:72]`.
- Assert `rst_n`=0 during the DATA bits of byte 2: `txd`=1, `busy`=0 immediately. After release, a new edge with `nummax`=3 produces a clean 120-cycle message.
- Change `data` and `nummax` every cycle after the start edge: the transmitted bytes match the values latched at start.

Source files
------------

// File: rtl/uart_frame_tx.sv
// uart_frame_tx
// -----------------------------------------------------------------------------
// UART 8N1 transmitter for the PC report link. On a rising edge of `en` it
// captures a right-aligned ASCII message and sends min(nummax, MAXBYTES)
// bytes. The most-significant used byte goes first and each byte is sent LSB
// first. Consecutive frames are sent with no idle gap between them.
//
// Ports
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   en      in   start request (only its rising edge matters)
//   data    in   message; byte k at data[8k+7:8k], byte nummax-1 sent first
//   nummax  in   number of bytes to send (0 = ignore request, >MAXBYTES clamps)
//   txd     out  serial line, idle high
//   busy    out  high while a message is in progress
//   done    out  one-cycle pulse on completion of the last stop bit
// -----------------------------------------------------------------------------
module uart_frame_tx #(
  parameter int BIT_CNT  = 703,
  parameter int MAXBYTES = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [8*MAXBYTES-1:0]   data,
  input  logic [5:0]              nummax,
  output logic                    txd,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [15:0] BIT_LAST  = 16'(BIT_CNT - 1);
  localparam logic [5:0]  MAX_N     = 6'(MAXBYTES);
  localparam logic [3:0]  LAST_IDX  = 4'(MAXBYTES - 1);

  state_t                  state_reg;
  logic                    en_d1_reg;
  logic [8*MAXBYTES-1:0]   data_l_reg;
  logic [15:0]             cnt_reg;
  logic [2:0]              bit_idx_reg;
  logic [3:0]              byte_idx_reg;
  logic                    txd_reg;
  logic                    busy_reg;
  logic                    done_reg;

  // Byte view of the held message. The table is padded to the full range of
  // the 4-bit byte index so the lookup can never fall outside the array.
  logic [7:0] byte_arr [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bytes
      if (gi < MAXBYTES) begin : g_used
        assign byte_arr[gi] = data_l_reg[8*gi +: 8];
      end else begin : g_pad
        assign byte_arr[gi] = 8'h00;
      end
    end
  endgenerate

  logic [7:0] cur_byte;
  logic       bit_end;
  logic       start_req;
  logic [3:0] start_last;

  assign cur_byte  = byte_arr[byte_idx_reg];
  assign bit_end   = (cnt_reg == BIT_LAST);
  assign start_req = en && !en_d1_reg && (nummax != 6'd0);

  // Index of the first byte to send: count-1, with the count clamped to the
  // register capacity.
  always_comb begin
    start_last = 4'd0;
    if (nummax > MAX_N) begin
      start_last = LAST_IDX;
    end else begin
      start_last = nummax[3:0] - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      en_d1_reg    <= 1'b0;
      data_l_reg   <= '0;
      cnt_reg      <= 16'd0;
      bit_idx_reg  <= 3'd0;
      byte_idx_reg <= 4'd0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      en_d1_reg <= en;
      done_reg  <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          txd_reg  <= 1'b1;
          busy_reg <= 1'b0;
          cnt_reg  <= 16'd0;
          if (start_req) begin
            data_l_reg   <= data;
            byte_idx_reg <= start_last;
            bit_idx_reg  <= 3'd0;
            txd_reg      <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            cnt_reg     <= 16'd0;
            bit_idx_reg <= 3'd0;
            txd_reg     <= cur_byte[0];
            state_reg   <= S_DATA;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cnt_reg <= 16'd0;
            if (bit_idx_reg == 3'd7) begin
              txd_reg   <= 1'b1;
              state_reg <= S_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              txd_reg     <= cur_byte[bit_idx_reg + 3'd1];
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            cnt_reg <= 16'd0;
            if (byte_idx_reg == 4'd0) begin
              // Line is already high from the stop bit; just close out.
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              // Next frame's start bit follows immediately.
              byte_idx_reg <= byte_idx_reg - 4'd1;
              txd_reg      <= 1'b0;
              state_reg    <= S_START;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end

        default: begin
          state_reg <= S_IDLE;
          txd_reg   <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign txd  = txd_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule
